// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversample tick generator, receive byte FIFO with valid/ready output, error tracking
module uart_rx_ctrl #(
  parameter int DivWidth    = 16,
  parameter int FifoDepth   = 4,
  parameter int ErrCntWidth = 8
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic                           enable,
  input  logic [DivWidth-1:0]            divisor,
  output logic                           rxEn,
  input  logic [7:0]                     rxData,
  input  logic                           rxDone,
  input  logic                           rxErr,
  output logic [7:0]                     outData,
  output logic                           outValid,
  input  logic                           outReady,
  output logic [$clog2(FifoDepth):0]     fifoCount,
  output logic                           overrun,
  output logic [ErrCntWidth-1:0]         frameErrCnt,
  input  logic                           clearErr
);
  localparam int PW = $clog2(FifoDepth);
  localparam int CW = PW + 1;

  logic [DivWidth-1:0] tick_cnt;
  logic [DivWidth-1:0] reload;
  logic [7:0]          mem [FifoDepth];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                push_req;
  logic                pop;
  logic                full;
  logic                push;
  logic                drop;
  logic                err_q;
  logic                err_edge;

  assign reload   = (divisor == '0) ? '0 : divisor - DivWidth'(1);
  assign full     = fifoCount == CW'(FifoDepth);
  assign push_req = rxEn && rxDone;
  assign pop      = outValid && outReady;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign err_edge = rxErr && !err_q;
  assign outValid = fifoCount != '0;
  assign outData  = outValid ? mem[rd_ptr] : '0;

  // tick generator: a zero count fires a registered tick and reloads; the divisor is only sampled at reload
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      tick_cnt <= '0;
      rxEn     <= 1'b0;
    end else if (!enable) begin
      tick_cnt <= '0;
      rxEn     <= 1'b0;
    end else begin
      rxEn     <= tick_cnt == '0;
      tick_cnt <= (tick_cnt == '0) ? reload : tick_cnt - DivWidth'(1);
    end

  // FIFO storage; no reset, since outData is masked while the FIFO is empty
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= rxData;

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifoCount <= fifoCount + CW'(push) - CW'(pop);
    end

  // sticky overrun and saturating error-edge counter; a new event beats a coincident clear
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      err_q       <= 1'b0;
      overrun     <= 1'b0;
      frameErrCnt <= '0;
    end else begin
      err_q       <= rxErr;
      overrun     <= clearErr ? drop : (overrun || drop);
      frameErrCnt <= clearErr ? ErrCntWidth'(err_edge) :
                     (err_edge && !(&frameErrCnt)) ? frameErrCnt + ErrCntWidth'(1) : frameErrCnt;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] divisor = '0;
  logic        rxEn;
  logic [7:0]  rxData = '0;
  logic        rxDone = 1'b0;
  logic        rxErr = 1'b0;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [2:0]  fifoCount;
  logic        overrun;
  logic [7:0]  frameErrCnt;
  logic        clearErr = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  pat;
  logic [3:0]  pat4;

  uart_rx_ctrl dut (
    .clk(clk), .nReset(nReset), .enable(enable), .divisor(divisor), .rxEn(rxEn),
    .rxData(rxData), .rxDone(rxDone), .rxErr(rxErr), .outData(outData),
    .outValid(outValid), .outReady(outReady), .fifoCount(fifoCount),
    .overrun(overrun), .frameErrCnt(frameErrCnt), .clearErr(clearErr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rxEn"}, 32'(rxEn), 0);
    check({tag, "_valid"}, 32'(outValid), 0);
    check({tag, "_data"}, 32'(outData), 0);
    check({tag, "_count"}, 32'(fifoCount), 0);
    check({tag, "_ovr"}, 32'(overrun), 0);
    check({tag, "_ferr"}, 32'(frameErrCnt), 0);
  endtask

  initial begin
    tick();
    tick();
    check_reset("reset");
    nReset = 1'b1;
    // tick spacing with divisor 4, then every cycle once divisor 0 is reloaded
    divisor = 16'd4;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      pat[i] = rxEn;
    end
    check("div4_pattern", 32'(pat), 32'h11);
    divisor = 16'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat4[i] = rxEn;
    end
    check("div0_pattern", 32'(pat4), 32'hf);
    // single push held until ready
    rxData = 8'h55;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    check("push_valid", 32'(outValid), 1);
    check("push_data", 32'(outData), 32'h55);
    check("push_count", 32'(fifoCount), 1);
    tick();
    tick();
    tick();
    check("hold_data", 32'(outData), 32'h55);
    check("hold_count", 32'(fifoCount), 1);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check("pop_valid", 32'(outValid), 0);
    check("pop_count", 32'(fifoCount), 0);
    // fill, overflow, drain in order
    rxDone = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      rxData = 8'(i);
      tick();
    end
    rxDone = 1'b0;
    check("full_count", 32'(fifoCount), 4);
    check("full_ovr", 32'(overrun), 1);
    outReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d", i), 32'(outData), 32'(i));
      tick();
    end
    outReady = 1'b0;
    check("drain_count", 32'(fifoCount), 0);
    check("drain_valid", 32'(outValid), 0);
    clearErr = 1'b1;
    tick();
    clearErr = 1'b0;
    check("clear_ovr", 32'(overrun), 0);
    // full FIFO with simultaneous push and pop
    rxDone = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rxData = 8'(i);
      tick();
    end
    rxData = 8'hAA;
    outReady = 1'b1;
    tick();
    rxDone = 1'b0;
    check("pp_count", 32'(fifoCount), 4);
    check("pp_ovr", 32'(overrun), 0);
    check("pp_head", 32'(outData), 2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp_drain%0d", i), 32'(outData), (i == 3) ? 32'hAA : 32'(i + 2));
      tick();
    end
    outReady = 1'b0;
    check("pp_empty", 32'(fifoCount), 0);
    // framing-error edges, saturation and clear priority
    rxErr = 1'b1;
    tick();
    rxErr = 1'b0;
    tick();
    check("ferr_one", 32'(frameErrCnt), 1);
    rxErr = 1'b1;
    tick();
    tick();
    tick();
    rxErr = 1'b0;
    tick();
    check("ferr_level", 32'(frameErrCnt), 2);
    for (int i = 0; i < 258; i++) begin
      rxErr = 1'b1;
      tick();
      rxErr = 1'b0;
      tick();
    end
    check("ferr_sat", 32'(frameErrCnt), 255);
    check("ferr_fifo", 32'(fifoCount), 0);
    clearErr = 1'b1;
    tick();
    check("ferr_clear", 32'(frameErrCnt), 0);
    rxErr = 1'b1;
    tick();
    clearErr = 1'b0;
    rxErr = 1'b0;
    check("ferr_clear_edge", 32'(frameErrCnt), 1);
    // divisor 2: rxDone held across three ticks gives three pushes
    enable = 1'b0;
    tick();
    check("disable_rxEn", 32'(rxEn), 0);
    divisor = 16'd2;
    enable = 1'b1;
    rxData = 8'h33;
    rxDone = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rxDone = 1'b0;
    check("div2_count", 32'(fifoCount), 3);
    check("div2_data", 32'(outData), 32'h33);
    check("div2_rxEn", 32'(rxEn), 0);
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    check("between_count", 32'(fifoCount), 3);
    // asynchronous reset mid-stream
    nReset = 1'b0;
    #1;
    check_reset("midreset");
    #3;
    nReset = 1'b1;
    enable = 1'b0;
    tick();
    check("post_reset_count", 32'(fifoCount), 0);
    check("post_reset_data", 32'(outData), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
